// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the read/write encodings
// also used by the bus master.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    RwRead  = 2'b01,
    RwWrite = 2'b11
  } apb_rw_e;

  // $clog2 clamped to at least one bit so degenerate parameters still yield legal vectors.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register storage for the APB completer: one synchronous write port, one registered read
// port that returns zero whenever no read is requested, and a live view of register 0.
module apb_regbank #(
  parameter int unsigned NumRegs = 8,
  parameter int unsigned IdxW    = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] widx_i,
  input  logic [31:0]     wdata_i,
  input  logic            re_i,
  input  logic [IdxW-1:0] ridx_i,
  output logic [31:0]     rdata_o,
  output logic [31:0]     reg0_o
);

  logic [31:0] mem_q [NumRegs];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[widx_i] <= wdata_i;
      end
      rdata_q <= re_i ? mem_q[ridx_i] : '0;
    end
  end

  assign rdata_o = rdata_q;
  assign reg0_o  = mem_q[0];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a small register file, programmable wait states and out-of-range
// error response. Register 0 is exported as ctrl_out.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned        NUM_REGS    = 8,
  parameter int unsigned        WAIT_STATES = 1,
  parameter logic [APB_AW-1:0]  BASE_ADDR   = '0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [APB_DW-1:0] ctrl_out
);

  localparam int unsigned   IdxW     = clog2_min1(NUM_REGS);
  localparam int unsigned   CntW     = clog2_min1(WAIT_STATES + 1);
  localparam bit            ZeroWait = (WAIT_STATES == 0);
  localparam logic [CntW-1:0] CntInit = CntW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  apb_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              valid_q;
  apb_rw_e           rw_q;
  logic [APB_DW-1:0] wdata_q;
  logic              pready_q;
  logic              pslverr_q;

  // Address decode; the 32-bit subtraction wraps on underflow, so paddr < BASE_ADDR is
  // rejected explicitly rather than relying on the word index.
  logic [APB_AW-1:0] offset;
  logic [APB_AW-1:0] word;
  logic              dec_valid;
  logic [IdxW-1:0]   dec_idx;

  assign offset    = paddr - BASE_ADDR;
  assign word      = offset >> 2;
  assign dec_valid = (paddr >= BASE_ADDR) && (word < NUM_REGS);
  assign dec_idx   = word[IdxW-1:0];

  logic            setup;
  logic            rd_en;
  logic            wr_en;
  logic [IdxW-1:0] rd_idx;

  assign setup = psel && !penable;

  // Read data is captured on the edge entering DONE; writes commit on the edge leaving it.
  always_comb begin
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    rd_idx = idx_q;
    unique case (state_q)
      StIdle: begin
        rd_idx = dec_idx;
        rd_en  = ZeroWait && setup && !pwrite && dec_valid;
      end
      StWait: rd_en = psel && (cnt_q == '0) && (rw_q == RwRead) && valid_q;
      StDone: wr_en = psel && penable && pwrite && valid_q;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      rw_q      <= RwRead;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (setup) begin
            idx_q   <= dec_idx;
            valid_q <= dec_valid;
            rw_q    <= pwrite ? RwWrite : RwRead;
            wdata_q <= pwdata;
            if (ZeroWait) begin
              state_q   <= StDone;
              pready_q  <= 1'b1;
              pslverr_q <= !dec_valid;
            end else begin
              cnt_q   <= CntInit;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!psel) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            state_q   <= StDone;
            pready_q  <= 1'b1;
            pslverr_q <= !valid_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  apb_regbank #(
    .NumRegs (NUM_REGS),
    .IdxW    (IdxW)
  ) u_regbank (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (wr_en),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .re_i    (rd_en),
    .ridx_i  (rd_idx),
    .rdata_o (prdata),
    .reg0_o  (ctrl_out)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (1, 0 and 3 wait states, one with a non-zero
// base) driven by directed APB transfers and checked every cycle against a transfer-level model.
module tb_apb_slave_regfile;

  localparam int NR = 8;

  logic        pclk = 1'b0;
  logic [2:0]  preset  = 3'b111;
  logic [2:0]  psel    = '0;
  logic [2:0]  penable = '0;
  logic [2:0]  pwrite  = '0;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] paddr    [3];
  logic [31:0] pwdata   [3];
  logic [31:0] prdata   [3];
  logic [31:0] ctrl_out [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
    .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .ctrl_out(ctrl_out[0])
  );
  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
    .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .ctrl_out(ctrl_out[1])
  );
  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(3), .BASE_ADDR(32'h1000)) u_ws3 (
    .pclk(pclk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]),
    .pready(pready[2]), .pslverr(pslverr[2]), .ctrl_out(ctrl_out[2])
  );

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h1000 : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Transfer-level model: a setup starts a transfer that completes ws+1 edges later unless
  // psel drops first; the completing cycle commits a qualified write.
  logic [31:0] m_regs [3][NR];
  bit          m_live [3];
  bit          m_pend [3];
  int          m_left [3];
  bit          m_rdy  [3];
  bit          m_err  [3];
  logic [31:0] m_rd   [3];
  bit          m_wr   [3];
  bit          m_valid[3];
  int          m_idx  [3];
  logic [31:0] m_data [3];

  task automatic model_finish(input int k);
    m_rdy[k] = 1'b1;
    m_err[k] = !m_valid[k];
    m_rd[k]  = (!m_wr[k] && m_valid[k]) ? m_regs[k][m_idx[k]] : 32'h0;
  endtask

  task automatic model_step(input int k);
    logic [31:0] off;
    if (preset[k]) begin
      for (int i = 0; i < NR; i++) m_regs[k][i] = '0;
      m_live[k] = 1'b1; m_pend[k] = 1'b0; m_rdy[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = '0;
    end else if (m_live[k]) begin
      if (m_rdy[k]) begin
        if (psel[k] && penable[k] && pwrite[k] && m_valid[k]) m_regs[k][m_idx[k]] = m_data[k];
        m_pend[k] = 1'b0; m_rdy[k] = 1'b0; m_err[k] = 1'b0; m_rd[k] = '0;
      end else if (m_pend[k]) begin
        if (!psel[k]) begin
          m_pend[k] = 1'b0;
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) model_finish(k);
        end
      end else if (psel[k] && !penable[k]) begin
        off        = paddr[k] - base_of(k);
        m_valid[k] = (paddr[k] >= base_of(k)) && ((off >> 2) < NR);
        m_idx[k]   = m_valid[k] ? int'(off >> 2) : 0;
        m_wr[k]    = pwrite[k];
        m_data[k]  = pwdata[k];
        m_pend[k]  = 1'b1;
        m_left[k]  = ws_of(k);
        if (m_left[k] == 0) model_finish(k);
      end
    end
  endtask

  // Inputs change just after posedge, so at negedge the outputs reflect the last edge and the
  // inputs are what the next edge samples.
  initial begin
    forever begin
      @(negedge pclk);
      for (int k = 0; k < 3; k++) begin
        if (m_live[k]) begin
          chk($sformatf("dut%0d pready", k), {31'b0, pready[k]}, {31'b0, m_rdy[k]});
          chk($sformatf("dut%0d pslverr", k), {31'b0, pslverr[k]}, {31'b0, m_err[k]});
          chk($sformatf("dut%0d prdata", k), prdata[k], m_rd[k]);
          chk($sformatf("dut%0d ctrl_out", k), ctrl_out[k], m_regs[k][0]);
        end
        model_step(k);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // Called just after a posedge; returns just after the edge that closes the DONE cycle.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit err, output int acc);
    bit seen = 1'b0;
    rd = '0; err = 1'b0; acc = 0;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge pclk); #1;
    penable[k] = 1'b1;
    while (!seen && acc < 16) begin
      @(negedge pclk);
      acc++;
      if (pready[k]) begin
        seen = 1'b1; rd = prdata[k]; err = pslverr[k];
      end
      @(posedge pclk); #1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL dut%0d xfer timeout addr=%h got=no_pready exp=pready", k, a);
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic do_rd(input int k, input logic [31:0] a, input logic [31:0] exp_rd,
                       input bit exp_err, input int exp_acc, input string name);
    logic [31:0] rd; bit err; int acc;
    xfer(k, 1'b0, a, 32'h0, rd, err, acc);
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " err"}, {31'b0, err}, {31'b0, exp_err});
    chk({name, " cycles"}, acc, exp_acc);
  endtask

  task automatic do_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                       input bit exp_err, input int exp_acc, input string name);
    logic [31:0] rd; bit err; int acc;
    xfer(k, 1'b1, a, d, rd, err, acc);
    chk({name, " err"}, {31'b0, err}, {31'b0, exp_err});
    chk({name, " cycles"}, acc, exp_acc);
  endtask

  int t0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      paddr[k] = '0; pwdata[k] = '0;
    end
    repeat (2) @(posedge pclk);
    #1 preset = '0;

    // Reset state
    chk("rst prdata", prdata[0], 32'h0);
    chk("rst pready", {31'b0, pready[0]}, 32'h0);
    chk("rst ctrl_out", ctrl_out[0], 32'h0);
    do_rd(0, 32'hC, 32'h0, 1'b0, 2, "rst rd reg3");

    // One wait state: write, read back, reg0 drives ctrl_out
    do_wr(0, 32'h8, 32'hDEAD_BEEF, 1'b0, 2, "ws1 wr 0x8");
    do_rd(0, 32'h8, 32'hDEAD_BEEF, 1'b0, 2, "ws1 rd 0x8");
    do_wr(0, 32'h0, 32'h5, 1'b0, 2, "ws1 wr 0x0");
    chk("ctrl_out after wr", ctrl_out[0], 32'h5);

    // Out-of-range accesses
    do_rd(0, 32'h20, 32'h0, 1'b1, 2, "err rd 0x20");
    do_wr(0, 32'h40, 32'hFFFF_FFFF, 1'b1, 2, "err wr 0x40");
    chk("model reg0 literal", m_regs[0][0], 32'h5);
    do_rd(0, 32'h0, 32'h5, 1'b0, 2, "rd 0x0 after err");

    // Back-to-back writes: 3 cycles each
    t0 = cyc;
    do_wr(0, 32'h4, 32'h1111, 1'b0, 2, "b2b wr 0x4");
    do_wr(0, 32'hC, 32'h3333, 1'b0, 2, "b2b wr 0xC");
    chk("b2b total cycles", cyc - t0, 6);
    do_rd(0, 32'h4, 32'h1111, 1'b0, 2, "b2b rd 0x4");
    do_rd(0, 32'hC, 32'h3333, 1'b0, 2, "b2b rd 0xC");

    // Zero wait states and three wait states with a non-zero base
    do_wr(1, 32'h10, 32'hA5A5, 1'b0, 1, "ws0 wr 0x10");
    do_rd(1, 32'h10, 32'hA5A5, 1'b0, 1, "ws0 rd 0x10");
    do_wr(2, 32'h1004, 32'hAAAA, 1'b0, 4, "ws3 wr 0x1004");
    do_rd(2, 32'h1004, 32'hAAAA, 1'b0, 4, "ws3 rd 0x1004");
    do_rd(2, 32'h0FFC, 32'h0, 1'b1, 4, "ws3 underflow");
    do_rd(2, 32'h1020, 32'h0, 1'b1, 4, "ws3 past end");

    // Abort by dropping psel mid-wait
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h1004; pwdata[2] = 32'h1234;
    @(posedge pclk); #1 penable[2] = 1'b1;
    @(posedge pclk); #1 psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge pclk); #1;
    chk("abort pready", {31'b0, pready[2]}, 32'h0);
    do_rd(2, 32'h1004, 32'hAAAA, 1'b0, 4, "abort rd reg1");

    // penable without a prior setup is ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h0BAD;
    repeat (3) @(posedge pclk);
    #1 psel[0] = 1'b0; penable[0] = 1'b0;
    do_rd(0, 32'h4, 32'h1111, 1'b0, 2, "stray penable rd");

    // Reset during the completing cycle wins over the write
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h4; pwdata[0] = 32'h1234;
    @(posedge pclk); #1 penable[0] = 1'b1;
    @(posedge pclk); #1 preset[0] = 1'b1;
    @(posedge pclk); #1 preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
    chk("rst abort pready", {31'b0, pready[0]}, 32'h0);
    chk("rst abort ctrl_out", ctrl_out[0], 32'h0);
    chk("model reg1 literal", m_regs[0][1], 32'h0);
    do_rd(0, 32'h4, 32'h0, 1'b0, 2, "rst abort rd reg1");

    repeat (2) @(posedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
